// File: rtl/cam_capture_rgb332.sv
// cam_capture_rgb332 -- camera capture stage for the RGB332 frame buffer.
//
// Samples an asynchronous camera bus (PCLK/HREF/VSYNC/D[7:0]) as plain data
// in the CLK domain, pairs RGB565 bytes into RGB332 pixels and emits one
// write strobe per pixel, clipped to SCREEN_WIDTH x SCREEN_HEIGHT.
//
// Optional feature: define CAPTURE_TEST_PATTERN_EN to replace camera pixel
// data with a fixed red/blue split pattern. Timing, addresses, W_EN and
// FRAME_DONE are the same in both builds.
module cam_capture_rgb332 #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int SYNC_STAGES   = 2    // must be at least 2
) (
  input  logic        CLK,
  input  logic        RESET_NEG,
  input  logic        CAM_PCLK,
  input  logic        CAM_HREF,
  input  logic        CAM_VSYNC,
  input  logic [7:0]  CAM_DATA,
  output logic [7:0]  PIXEL_OUT,
  output logic [14:0] X_ADDR,
  output logic [14:0] Y_ADDR,
  output logic        W_EN,
  output logic        FRAME_DONE
);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_LINE,
    BYTE_HI,
    BYTE_LO
  } state_t;

  localparam logic [14:0] X_LIMIT  = 15'(SCREEN_WIDTH);
  localparam logic [14:0] Y_LIMIT  = 15'(SCREEN_HEIGHT);
  localparam logic [14:0] ADDR_MAX = 15'h7FFF;
`ifdef CAPTURE_TEST_PATTERN_EN
  localparam logic [14:0] X_SPLIT  = 15'(SCREEN_WIDTH / 2);
`endif

  // Synchroniser chains; CAM_DATA gets the same depth so it lines up with PCLK.
  logic [SYNC_STAGES-1:0] pclk_sr;
  logic [SYNC_STAGES-1:0] href_sr;
  logic [SYNC_STAGES-1:0] vsync_sr;
  logic [7:0]             data_sr [SYNC_STAGES];

  // Previous synchronised levels for edge detection.
  logic pclk_q;
  logic href_q;
  logic vsync_q;

  logic       pclk_s;
  logic       href_s;
  logic       vsync_s;
  logic [7:0] data_s;

  logic pclk_rise;
  logic href_fall;
  logic vsync_rise;
  logic vsync_fall;
  logic byte_take;

  state_t      state;
  logic [5:0]  hi_rg;       // R[4:2] and G[5:3] kept from the high byte
  logic [14:0] x_cnt;
  logic [14:0] y_cnt;
  logic        in_window;
  logic [7:0]  pixel_next;

  // One-cycle pipeline between the low byte and the registered write.
  logic        pend_valid;
  logic [7:0]  pend_pixel;
  logic [14:0] pend_x;
  logic [14:0] pend_y;

  // Shift every camera input through SYNC_STAGES flops.
  always_ff @(posedge CLK or negedge RESET_NEG) begin
    // NOTE: the data delay line is a small register array, not a RAM, so
    // clearing it on reset is cheap and keeps stale bytes out after reset.
    if (!RESET_NEG) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
    end else begin
      pclk_sr    <= {pclk_sr[SYNC_STAGES-2:0], CAM_PCLK};
      href_sr    <= {href_sr[SYNC_STAGES-2:0], CAM_HREF};
      vsync_sr   <= {vsync_sr[SYNC_STAGES-2:0], CAM_VSYNC};
      data_sr[0] <= CAM_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign pclk_s  = pclk_sr[SYNC_STAGES-1];
  assign href_s  = href_sr[SYNC_STAGES-1];
  assign vsync_s = vsync_sr[SYNC_STAGES-1];
  assign data_s  = data_sr[SYNC_STAGES-1];

  // Remember last synchronised levels so edges are seen for exactly one CLK.
  always_ff @(posedge CLK or negedge RESET_NEG) begin
    if (!RESET_NEG) begin
      pclk_q  <= 1'b0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      pclk_q  <= pclk_s;
      href_q  <= href_s;
      vsync_q <= vsync_s;
    end
  end

  assign pclk_rise  = pclk_s & ~pclk_q;
  assign href_fall  = ~href_s & href_q;
  assign vsync_rise = vsync_s & ~vsync_q;
  assign vsync_fall = ~vsync_s & vsync_q;
  // A PCLK rise coinciding with an HREF fall sees href_s=0 and takes nothing.
  assign byte_take  = pclk_rise & href_s;
  assign in_window  = (x_cnt < X_LIMIT) && (y_cnt < Y_LIMIT);

  // Pixel value formed from the stored high byte and the current low byte.
  always_comb begin
`ifdef CAPTURE_TEST_PATTERN_EN
    pixel_next = (x_cnt < X_SPLIT) ? 8'hE0 : 8'h03;
`else
    pixel_next = {hi_rg[5:3], hi_rg[2:0], data_s[4:3]};
`endif
  end

  // Capture FSM: byte pairing, line/frame tracking and the registered write port.
  always_ff @(posedge CLK or negedge RESET_NEG) begin
    if (!RESET_NEG) begin
      state      <= WAIT_FRAME;
      hi_rg      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      pend_valid <= 1'b0;
      pend_pixel <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      PIXEL_OUT  <= '0;
      X_ADDR     <= '0;
      Y_ADDR     <= '0;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the pre-edge values of state and counters regardless of order.
      W_EN       <= pend_valid;
      FRAME_DONE <= 1'b0;
      pend_valid <= 1'b0;
      if (pend_valid) begin
        PIXEL_OUT <= pend_pixel;
        X_ADDR    <= pend_x;
        Y_ADDR    <= pend_y;
      end

      if (state == WAIT_FRAME) begin
        if (vsync_fall) begin
          x_cnt  <= '0;
          y_cnt  <= '0;
          X_ADDR <= '0;
          Y_ADDR <= '0;
          state  <= WAIT_LINE;
        end
      end else if (vsync_rise) begin
        // Frame ends; any half-received pixel is abandoned.
        FRAME_DONE <= 1'b1;
        state      <= WAIT_FRAME;
      end else if (href_fall) begin
        x_cnt <= '0;
        if (state != WAIT_LINE) begin
          if (y_cnt != ADDR_MAX) y_cnt <= y_cnt + 15'd1;
          state <= WAIT_LINE;
        end
      end else if (byte_take) begin
        if (state == BYTE_LO) begin
          pend_valid <= in_window;
          pend_pixel <= pixel_next;
          pend_x     <= x_cnt;
          pend_y     <= y_cnt;
          if (x_cnt != ADDR_MAX) x_cnt <= x_cnt + 15'd1;
          state      <= BYTE_HI;
        end else begin
          hi_rg <= {data_s[7:5], data_s[2:0]};
          state <= BYTE_LO;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// tb_cam_capture_rgb332 -- randomized bench for cam_capture_rgb332.
// A line-level model turns each driven line of bytes into the list of
// writes it should produce; a monitor records what the DUT actually writes.
module tb_cam_capture_rgb332;

  localparam int W    = 176;
  localparam int H    = 144;
  localparam int SYNC = 2;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic [7:0]  pix;
    logic [14:0] x;
    logic [14:0] y;
  } wr_t;

  logic        CLK;
  logic        RESET_NEG;
  logic        CAM_PCLK;
  logic        CAM_HREF;
  logic        CAM_VSYNC;
  logic [7:0]  CAM_DATA;
  logic [7:0]  PIXEL_OUT;
  logic [14:0] X_ADDR;
  logic [14:0] Y_ADDR;
  logic        W_EN;
  logic        FRAME_DONE;

  int  total;
  int  bad;
  int  fd_cnt;
  int  model_y;
  wr_t obs_q [$];
  wr_t exp_q [$];

  cam_capture_rgb332 #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .CLK       (CLK),
    .RESET_NEG (RESET_NEG),
    .CAM_PCLK  (CAM_PCLK),
    .CAM_HREF  (CAM_HREF),
    .CAM_VSYNC (CAM_VSYNC),
    .CAM_DATA  (CAM_DATA),
    .PIXEL_OUT (PIXEL_OUT),
    .X_ADDR    (X_ADDR),
    .Y_ADDR    (Y_ADDR),
    .W_EN      (W_EN),
    .FRAME_DONE(FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every write and frame-done pulse away from the active edge.
  always @(negedge CLK) begin
    if (RESET_NEG) begin
      if (W_EN) obs_q.push_back({PIXEL_OUT, X_ADDR, Y_ADDR});
      if (FRAME_DONE) fd_cnt++;
    end
  end

  function automatic logic [7:0] model_pixel(input logic [7:0] hi, input logic [7:0] lo,
                                             input int x);
`ifdef CAPTURE_TEST_PATTERN_EN
    return (x < W / 2) ? 8'b111_000_00 : 8'b000_000_11;
`else
    // R = hi[7:3] top 3 bits, G = {hi[2:0],lo[7:5]} top 3 bits, B = lo[4:0] top 2 bits
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = hi[7:3];
    g = {hi[2:0], lo[7:5]};
    b = lo[4:0];
    return {r[4:2], g[5:3], b[4:3]};
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #3;
  endtask

  // Drive one line at PCLK = CLK/4 and add its expected writes to exp_q.
  task automatic drive_line(input byte_q_t bytes, input bit drop_href);
    int npix;
    npix = bytes.size() / 2;
    for (int i = 0; i < npix; i++)
      if (i < W && model_y < H)
        exp_q.push_back({model_pixel(bytes[2*i], bytes[2*i+1], i), 15'(i), 15'(model_y)});
    if (drop_href && bytes.size() > 0) model_y++;

    CAM_PCLK = 1'b0;
    CAM_HREF = 1'b1;
    if (bytes.size() == 0) wait_clk(4);
    foreach (bytes[i]) begin
      CAM_PCLK = 1'b0;
      CAM_DATA = bytes[i];
      wait_clk(2);
      CAM_PCLK = 1'b1;
      wait_clk(2);
    end
    CAM_PCLK = 1'b0;
    if (drop_href) begin
      CAM_HREF = 1'b0;
      for (int k = 0; k < 2; k++) begin
        wait_clk(2);
        CAM_PCLK = 1'b1;
        wait_clk(2);
        CAM_PCLK = 1'b0;
      end
    end else begin
      wait_clk(2);
    end
  endtask

  task automatic frame_start();
    CAM_VSYNC = 1'b1;
    wait_clk(8);
    CAM_VSYNC = 1'b0;
    wait_clk(8);
    model_y = 0;
  endtask

  task automatic end_frame();
    CAM_VSYNC = 1'b1;
    wait_clk(8);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  task automatic rand_bytes(input int n, output byte_q_t q);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    byte_q_t b;
    RESET_NEG = 1'b0;
    wait_clk(3);
    total++; if (W_EN !== 1'b0)      begin bad++; $display("FAIL reset_w_en: got %b want 0", W_EN); end
    total++; if (PIXEL_OUT !== 8'h0) begin bad++; $display("FAIL reset_pixel: got %h want 00", PIXEL_OUT); end
    total++; if (X_ADDR !== 15'h0)   begin bad++; $display("FAIL reset_x: got %0d want 0", X_ADDR); end
    total++; if (Y_ADDR !== 15'h0)   begin bad++; $display("FAIL reset_y: got %0d want 0", Y_ADDR); end
    total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", FRAME_DONE); end
    RESET_NEG = 1'b1;
    wait_clk(4);
    frame_start();
    b = '{8'hAB, 8'hCD, 8'hEF};
    drive_line(b, 1'b0);
    RESET_NEG = 1'b0;
    wait_clk(1);
    total++; if (W_EN !== 1'b0)      begin bad++; $display("FAIL midline_reset_w_en: got %b want 0", W_EN); end
    total++; if (PIXEL_OUT !== 8'h0) begin bad++; $display("FAIL midline_reset_pixel: got %h want 00", PIXEL_OUT); end
    total++; if (X_ADDR !== 15'h0 || Y_ADDR !== 15'h0)
      begin bad++; $display("FAIL midline_reset_addr: got x=%0d y=%0d want 0/0", X_ADDR, Y_ADDR); end
    CAM_HREF = 1'b0;
    wait_clk(2);
    RESET_NEG = 1'b1;
    wait_clk(4);
    clear_logs();
    rand_bytes(6, b);
    drive_line(b, 1'b1);
    wait_clk(8);
    total++; if (obs_q.size() != 0)
      begin bad++; $display("FAIL no_write_before_vsync: got %0d writes want 0", obs_q.size()); end
    total++; if (fd_cnt != 0)
      begin bad++; $display("FAIL no_fd_before_vsync: got %0d want 0", fd_cnt); end
  endtask

  task automatic test_basic();
    byte_q_t b;
    frame_start();
    clear_logs();
    b = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    drive_line(b, 1'b1);
    end_frame();
`ifndef CAPTURE_TEST_PATTERN_EN
    total++; if (exp_q.size() != 3 || exp_q[0].pix !== 8'hE0 || exp_q[1].pix !== 8'h1C || exp_q[2].pix !== 8'h03)
      begin bad++; $display("FAIL basic_model_sanity: model disagrees with E0,1C,03"); end
`endif
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL basic_fd: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_clip_width();
    byte_q_t b;
    frame_start();
    clear_logs();
    rand_bytes(360, b);
    drive_line(b, 1'b1);
    rand_bytes(4, b);
    drive_line(b, 1'b1);
    end_frame();
    total++; if (obs_q.size() != 178)
      begin bad++; $display("FAIL width_count: got %0d want 178", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL width_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_clip_height();
    byte_q_t b;
    frame_start();
    clear_logs();
    for (int l = 0; l < H + 1; l++) begin
      rand_bytes(4, b);
      drive_line(b, 1'b1);
    end
    end_frame();
    total++; if (obs_q.size() != exp_q.size() || obs_q.size() != 2 * H)
      begin bad++; $display("FAIL height_count: got %0d want %0d", obs_q.size(), 2 * H); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL height_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    total++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].y !== 15'(H - 1))
      begin bad++; $display("FAIL height_last_y: got %0d writes, want last y=%0d", obs_q.size(), H - 1); end
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL height_fd: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_orphan();
    byte_q_t b;
    frame_start();
    clear_logs();
    rand_bytes(5, b);
    drive_line(b, 1'b1);
    rand_bytes(4, b);
    drive_line(b, 1'b1);
    end_frame();
    total++; if (obs_q.size() != 4)
      begin bad++; $display("FAIL orphan_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL orphan_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_vsync_pending();
    byte_q_t b;
    frame_start();
    clear_logs();
    rand_bytes(3, b);
    drive_line(b, 1'b0);
    CAM_VSYNC = 1'b1;
    wait_clk(8);
    CAM_HREF = 1'b0;
    wait_clk(4);
    total++; if (fd_cnt != 1) begin bad++; $display("FAIL pending_fd: got %0d want 1", fd_cnt); end
    total++; if (obs_q.size() != 1)
      begin bad++; $display("FAIL pending_count: got %0d want 1", obs_q.size()); end
    frame_start();
    rand_bytes(2, b);
    drive_line(b, 1'b1);
    end_frame();
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL pending_total: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL pending_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    total++; if (fd_cnt != 2) begin bad++; $display("FAIL pending_fd_total: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_random();
    byte_q_t b;
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      frame_start();
      for (int l = 0; l < int'($urandom_range(6, 1)); l++) begin
        rand_bytes(int'($urandom_range(9, 0)), b);
        drive_line(b, 1'b1);
      end
      end_frame();
    end
    total++; if (obs_q.size() != exp_q.size())
      begin bad++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_write[%0d]: got pix=%h x=%0d y=%0d want pix=%h x=%0d y=%0d", i,
                 obs_q[i].pix, obs_q[i].x, obs_q[i].y, exp_q[i].pix, exp_q[i].x, exp_q[i].y);
      end
    end
    total++; if (fd_cnt != 3) begin bad++; $display("FAIL random_fd: got %0d want 3", fd_cnt); end
  endtask

  task automatic test_latency();
    logic [7:0] hi;
    logic [7:0] lo;
    int  n;
    bit  found;
    frame_start();
    clear_logs();
    hi = 8'($urandom);
    lo = 8'($urandom);
    exp_q.push_back({model_pixel(hi, lo, 0), 15'd0, 15'd0});
    CAM_HREF = 1'b1;
    CAM_PCLK = 1'b0;
    CAM_DATA = hi;
    wait_clk(2);
    CAM_PCLK = 1'b1;
    wait_clk(2);
    CAM_PCLK = 1'b0;
    CAM_DATA = lo;
    wait_clk(2);
    CAM_PCLK = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (W_EN) begin
        found = 1'b1;
        n = i;
      end
    end
    total++; if (n != SYNC + 2)
      begin bad++; $display("FAIL latency: got %0d clks want %0d", n, SYNC + 2); end
    wait_clk(1);
    CAM_PCLK = 1'b0;
    CAM_HREF = 1'b0;
    wait_clk(4);
    end_frame();
    total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0])
      begin bad++; $display("FAIL latency_write: got %0d writes, want 1 matching model", obs_q.size()); end
  endtask

`ifdef CAPTURE_TEST_PATTERN_EN
  task automatic test_pattern();
    byte_q_t b;
    frame_start();
    clear_logs();
    rand_bytes(180, b);
    drive_line(b, 1'b1);
    end_frame();
    total++; if (obs_q.size() < 89 || obs_q[87].x !== 15'd87 || obs_q[87].pix !== 8'hE0)
      begin bad++; $display("FAIL pattern_x87: got %0d writes, want pix E0 at x=87", obs_q.size()); end
    total++; if (obs_q.size() < 89 || obs_q[88].x !== 15'd88 || obs_q[88].pix !== 8'h03)
      begin bad++; $display("FAIL pattern_x88: got %0d writes, want pix 03 at x=88", obs_q.size()); end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    fd_cnt    = 0;
    model_y   = 0;
    RESET_NEG = 1'b0;
    CAM_PCLK  = 1'b0;
    CAM_HREF  = 1'b0;
    CAM_VSYNC = 1'b0;
    CAM_DATA  = 8'h00;
    test_reset();
    test_basic();
    test_clip_width();
    test_clip_height();
    test_orphan();
    test_vsync_pending();
    test_random();
    test_latency();
`ifdef CAPTURE_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
